// File: rtl/life_grid_scan.sv
// Row-scanned 8x8 LED driver for the Game of Life grid. New generations are
// staged in a shadow register and only reach the display at a frame boundary.

module life_row_pop (
    input  logic [7:0] bits,
    output logic [3:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, bits[i]};
    end
endmodule

module life_grid_scan #(
    parameter int ROW_DWELL = 1000,
    parameter int BLANK     = 2,
    parameter int GEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      grid,
    input  logic             grid_valid,
    output logic [7:0]       row_sel,
    output logic [7:0]       col_data,
    output logic             frame_done,
    output logic [GEN_W-1:0] gen_count,
    output logic [6:0]       pop_count
);
    localparam int              DW_W     = $clog2(ROW_DWELL);
    localparam logic [0:0]      IDLE     = 1'b0;
    localparam logic [0:0]      SCAN     = 1'b1;
    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(ROW_DWELL - 1);
    localparam logic [DW_W-1:0] DW_BLANK = DW_W'(BLANK);

    logic [0:0]      state;
    logic [2:0]      row;
    logic [DW_W-1:0] dwell;
    logic [63:0]     active;
    logic [63:0]     shadow;
    logic            pending;

    logic [7:0][7:0] active_rows;
    logic [7:0][3:0] row_pop;
    logic [6:0]      pop_sum;
    logic            boundary;
    logic            lit;

    assign active_rows = active;

    genvar r;
    generate
        for (r = 0; r < 8; r++) begin : g_row
            life_row_pop u_pop (.bits(active_rows[r]), .cnt(row_pop[r]));
        end
    endgenerate

    always_comb begin
        pop_sum = '0;
        for (int i = 0; i < 8; i++) pop_sum = pop_sum + {3'b000, row_pop[i]};
    end

    // Outputs decode registered state only; the leading BLANK cycles of each
    // row keep the matrix dark while row drivers settle.
    assign boundary   = (state == SCAN) && (row == 3'd7) && (dwell == DW_LAST);
    assign lit        = (state == SCAN) && (dwell >= DW_BLANK);
    assign frame_done = boundary;
    assign row_sel    = lit ? (8'h01 << row) : 8'h00;
    assign col_data   = lit ? active_rows[row] : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row       <= '0;
            dwell     <= '0;
            active    <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            gen_count <= '0;
            pop_count <= '0;
        end else begin
            pop_count <= pop_sum;
            case (state)
                IDLE: begin
                    if (grid_valid) begin
                        active    <= grid;
                        gen_count <= gen_count + GEN_W'(1);
                        row       <= '0;
                        dwell     <= '0;
                        state     <= SCAN;
                    end
                end
                default: begin
                    if (boundary) begin
                        dwell <= '0;
                        row   <= '0;
                        // A strobe landing in the boundary cycle goes straight
                        // to the display; the stale shadow is dropped.
                        if (grid_valid) begin
                            active    <= grid;
                            pending   <= 1'b0;
                            gen_count <= gen_count + GEN_W'(1);
                        end else if (pending) begin
                            active    <= shadow;
                            pending   <= 1'b0;
                            gen_count <= gen_count + GEN_W'(1);
                        end
                    end else begin
                        if (grid_valid) begin
                            shadow  <= grid;
                            pending <= 1'b1;
                        end
                        if (dwell == DW_LAST) begin
                            dwell <= '0;
                            row   <= row + 3'd1;
                        end else begin
                            dwell <= dwell + DW_W'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_life_grid_scan.sv
// Directed bench for life_grid_scan with ROW_DWELL=4, BLANK=1 (32-cycle frame),
// plus a GEN_W=3 instance for the generation counter wrap.

module tb_life_grid_scan;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] grid, grid_w;
    logic        grid_valid, grid_valid_w;
    logic [7:0]  row_sel, col_data, row_sel_w, col_data_w;
    logic        frame_done, frame_done_w;
    logic [15:0] gen_count;
    logic [2:0]  gen_count_w;
    logic [6:0]  pop_count, pop_count_w;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    life_grid_scan #(.ROW_DWELL(4), .BLANK(1), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .grid(grid), .grid_valid(grid_valid),
        .row_sel(row_sel), .col_data(col_data), .frame_done(frame_done),
        .gen_count(gen_count), .pop_count(pop_count)
    );

    life_grid_scan #(.ROW_DWELL(4), .BLANK(1), .GEN_W(3)) dut_w (
        .clk(clk), .reset(reset), .grid(grid_w), .grid_valid(grid_valid_w),
        .row_sel(row_sel_w), .col_data(col_data_w), .frame_done(frame_done_w),
        .gen_count(gen_count_w), .pop_count(pop_count_w)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; grid = '0; grid_valid = 1'b0; grid_w = '0; grid_valid_w = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (c == 5) reset = 1'b1;
            tick;
            checks++;
            if ({row_sel, col_data, frame_done} !== 17'h0 || gen_count !== 16'd0 || pop_count !== 7'd0) begin
                errors++;
                $display("FAIL reset_idle c=%0d: row_sel=%h col=%h fd=%b gen=%0d pop=%0d, want all zero",
                         c, row_sel, col_data, frame_done, gen_count, pop_count);
            end
        end
    endtask

    task automatic test_first_frame;
        logic [63:0] g;
        logic [7:0]  er, ec;
        int          r, d;
        g = 64'h0102040810204080;
        grid = g; grid_valid = 1'b1;
        tick;
        grid_valid = 1'b0; grid = '0;
        for (int k = 0; k < 32; k++) begin
            if (k != 0) tick;
            r = k / 4; d = k % 4;
            er = (d < 1) ? 8'h00 : (8'h01 << r);
            ec = (d < 1) ? 8'h00 : g[8*r +: 8];
            checks++;
            if (row_sel !== er || col_data !== ec) begin
                errors++;
                $display("FAIL first_frame scan k=%0d: row_sel=%h col=%h, want %h %h", k, row_sel, col_data, er, ec);
            end
            checks++;
            if (frame_done !== (k == 31)) begin
                errors++;
                $display("FAIL first_frame frame_done k=%0d: got %b want %b", k, frame_done, k == 31);
            end
            checks++;
            if (gen_count !== 16'd1 || pop_count !== ((k == 0) ? 7'd0 : 7'd8)) begin
                errors++;
                $display("FAIL first_frame counters k=%0d: gen=%0d pop=%0d, want 1 %0d", k, gen_count, pop_count, (k == 0) ? 0 : 8);
            end
        end
    endtask

    task automatic test_tear_free;
        logic [63:0] g_old, g_new;
        logic [7:0]  er, ec;
        int          r, d;
        g_old = 64'h0102040810204080;
        g_new = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 32; k++) begin
            tick;
            r = k / 4; d = k % 4;
            er = (d < 1) ? 8'h00 : (8'h01 << r);
            ec = (d < 1) ? 8'h00 : g_old[8*r +: 8];
            checks++;
            if (row_sel !== er || col_data !== ec || gen_count !== 16'd1) begin
                errors++;
                $display("FAIL tear_old k=%0d: row_sel=%h col=%h gen=%0d, want %h %h 1", k, row_sel, col_data, gen_count, er, ec);
            end
            if (k == 12) begin grid = g_new; grid_valid = 1'b1; end
            else grid_valid = 1'b0;
        end
        for (int k = 0; k < 32; k++) begin
            tick;
            r = k / 4; d = k % 4;
            er = (d < 1) ? 8'h00 : (8'h01 << r);
            ec = (d < 1) ? 8'h00 : 8'hFF;
            checks++;
            if (row_sel !== er || col_data !== ec || frame_done !== (k == 31)) begin
                errors++;
                $display("FAIL tear_new k=%0d: row_sel=%h col=%h fd=%b, want %h %h %b", k, row_sel, col_data, frame_done, er, ec, k == 31);
            end
            checks++;
            if (gen_count !== 16'd2 || pop_count !== ((k == 0) ? 7'd8 : 7'd64)) begin
                errors++;
                $display("FAIL tear_counters k=%0d: gen=%0d pop=%0d, want 2 %0d", k, gen_count, pop_count, (k == 0) ? 8 : 64);
            end
        end
    endtask

    task automatic test_coalesce;
        logic [7:0] er, ec;
        int         r, d;
        // Frame still showing all-ones; three strobes coalesce into the shadow.
        for (int k = 0; k < 32; k++) begin
            tick;
            d = k % 4;
            ec = (d < 1) ? 8'h00 : 8'hFF;
            checks++;
            if (col_data !== ec || gen_count !== 16'd2) begin
                errors++;
                $display("FAIL coalesce_hold k=%0d: col=%h gen=%0d, want %h 2", k, col_data, gen_count, ec);
            end
            grid_valid = 1'b0;
            if (k == 2)  begin grid = 64'd1; grid_valid = 1'b1; end
            if (k == 10) begin grid = 64'd3; grid_valid = 1'b1; end
            if (k == 20) begin grid = 64'd7; grid_valid = 1'b1; end
        end
        for (int k = 0; k < 32; k++) begin
            tick;
            r = k / 4; d = k % 4;
            er = (d < 1) ? 8'h00 : (8'h01 << r);
            ec = (d < 1 || r != 0) ? 8'h00 : 8'h07;
            checks++;
            if (row_sel !== er || col_data !== ec || gen_count !== 16'd3 || pop_count !== ((k == 0) ? 7'd64 : 7'd3)) begin
                errors++;
                $display("FAIL coalesce_last k=%0d: row_sel=%h col=%h gen=%0d pop=%0d, want %h %h 3 %0d",
                         k, row_sel, col_data, gen_count, pop_count, er, ec, (k == 0) ? 64 : 3);
            end
            if (k == 31) begin grid = 64'd5; grid_valid = 1'b1; end
        end
        for (int k = 0; k < 32; k++) begin
            tick;
            grid_valid = 1'b0;
            r = k / 4; d = k % 4;
            ec = (d < 1 || r != 0) ? 8'h00 : 8'h05;
            checks++;
            if (col_data !== ec || gen_count !== 16'd4 || pop_count !== ((k == 0) ? 7'd3 : 7'd2)) begin
                errors++;
                $display("FAIL boundary_bypass k=%0d: col=%h gen=%0d pop=%0d, want %h 4 %0d",
                         k, col_data, gen_count, pop_count, ec, (k == 0) ? 3 : 2);
            end
        end
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 22; k++) tick;
        checks++;
        if (row_sel !== 8'h20) begin
            errors++;
            $display("FAIL async_pre row_sel: got %h want 20", row_sel);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({row_sel, col_data, frame_done} !== 17'h0 || gen_count !== 16'd0 || pop_count !== 7'd0) begin
            errors++;
            $display("FAIL async_immediate: row_sel=%h col=%h fd=%b gen=%0d pop=%0d, want all zero",
                     row_sel, col_data, frame_done, gen_count, pop_count);
        end
        tick; tick;
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick;
            checks++;
            if (row_sel !== 8'h00 || frame_done !== 1'b0 || gen_count !== 16'd0) begin
                errors++;
                $display("FAIL async_idle c=%0d: row_sel=%h fd=%b gen=%0d, want 00 0 0", c, row_sel, frame_done, gen_count);
            end
        end
        grid = 64'h0102040810204080; grid_valid = 1'b1;
        tick;
        grid_valid = 1'b0;
        checks++;
        if (row_sel !== 8'h00 || gen_count !== 16'd1) begin
            errors++;
            $display("FAIL async_restart blank: row_sel=%h gen=%0d, want 00 1", row_sel, gen_count);
        end
        tick;
        checks++;
        if (row_sel !== 8'h01 || col_data !== 8'h80) begin
            errors++;
            $display("FAIL async_restart lit: row_sel=%h col=%h, want 01 80", row_sel, col_data);
        end
    endtask

    task automatic test_wrap;
        logic [2:0] eg;
        logic [7:0] ib;
        for (int i = 1; i <= 9; i++) begin
            grid_w = 64'(i); grid_valid_w = 1'b1;
            tick;
            grid_valid_w = 1'b0;
            repeat (33) tick;
            eg = 3'(i);
            ib = 8'(i);
            checks++;
            if (gen_count_w !== eg || pop_count_w !== 7'($countones(i))) begin
                errors++;
                $display("FAIL wrap i=%0d: gen=%0d pop=%0d, want %0d %0d", i, gen_count_w, pop_count_w, eg, $countones(i));
            end
            checks++;
            if ((col_data_w & ~ib) !== 8'h00 || $countones(row_sel_w) > 1 || (frame_done_w && row_sel_w !== 8'h80)) begin
                errors++;
                $display("FAIL wrap_scan i=%0d: row_sel=%h col=%h fd=%b", i, row_sel_w, col_data_w, frame_done_w);
            end
        end
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_tear_free;
        test_coalesce;
        test_async_reset;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
